// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one stage per shift-amount bit, valid/ready handshake,
// logical / arithmetic / rotate modes, whole pipe stalls as one when the output is blocked.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_zero
);

    logic advance_s;
    logic out_zero_r;

    // Single power-of-two step; mode 11 falls through to the logical behaviour.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int unsigned      amt,
        input logic             right,
        input logic [1:0]       md
    );
        logic [WIDTH-1:0] r;
        case (md)
            2'b01: begin
                if (right) r = $signed(d) >>> amt;
                else       r = d << amt;
            end
            2'b10: begin
                if (right) r = (d >> amt) | (d << (WIDTH - amt));
                else       r = (d << amt) | (d >> (WIDTH - amt));
            end
            default: begin
                if (right) r = d >> amt;
                else       r = d << amt;
            end
        endcase
        return r;
    endfunction

    assign advance_s = ~out_valid | out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = 32'd1 << k;

        logic                 in_valid_s;
        logic [WIDTH-1:0]     in_data_s;
        logic [SHW-k-1:0]     in_shift_s;
        logic                 in_dir_s;
        logic [1:0]           in_mode_s;
        logic [WIDTH-1:0]     next_data_s;
        logic                 valid_r;
        logic [WIDTH-1:0]     data_r;

        if (k == 0) begin : g_src
            assign in_valid_s = in_valid;
            assign in_data_s  = data_in;
            assign in_shift_s = shift;
            assign in_dir_s   = dir;
            assign in_mode_s  = mode;
        end else begin : g_src
            assign in_valid_s = g_stage[k-1].valid_r;
            assign in_data_s  = g_stage[k-1].data_r;
            assign in_shift_s = g_stage[k-1].g_carry.shift_r;
            assign in_dir_s   = g_stage[k-1].g_carry.dir_r;
            assign in_mode_s  = g_stage[k-1].g_carry.mode_r;
        end

        // Each stage consumes the low bit of the shift amount it receives.
        assign next_data_s = in_shift_s[0] ? shift_step(in_data_s, AMT, in_dir_s, in_mode_s)
                                           : in_data_s;

        // Stage valid/data register; holds while the output is stalled.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                data_r  <= '0;
            end else if (advance_s) begin
                valid_r <= in_valid_s;
                data_r  <= next_data_s;
            end
        end

        if (k < SHW - 1) begin : g_carry
            logic [SHW-k-2:0] shift_r;
            logic             dir_r;
            logic [1:0]       mode_r;

            // Remaining shift bits and control travel with the beat.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shift_r <= '0;
                    dir_r   <= 1'b0;
                    mode_r  <= 2'b00;
                end else if (advance_s) begin
                    shift_r <= in_shift_s[SHW-k-1:1];
                    dir_r   <= in_dir_s;
                    mode_r  <= in_mode_s;
                end
            end
        end
    end

    // Zero flag registered alongside the final stage data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_zero_r <= 1'b0;
        end else if (advance_s) begin
            out_zero_r <= (g_stage[SHW-1].next_data_s == '0);
        end
    end

    assign out_valid = g_stage[SHW-1].valid_r;
    assign data_out  = g_stage[SHW-1].data_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH = 8): directed vectors,
// stall and reset sequences, and randomised traffic against an arithmetic reference model.
module tb_barrel_shifter_pipe;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [2:0] shift;
    logic       dir;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift(shift), .dir(dir), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_zero(out_zero)
    );

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       dr;
        logic [1:0] m;
        logic [7:0] exp;
        logic       ez;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_zero  = 1'b0;
    int         popped     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference computed with integer multiply/divide on byte values.
    function automatic logic [7:0] ref_model(input logic [7:0] d, input int s,
                                             input logic dr, input logic [1:0] m);
        int v = int'(d);
        int p = 1 << s;
        int r;
        if (m == 2'b10) begin
            if (dr) r = v / p + (v % p) * (256 / p);
            else    r = (v * p) % 256 + v / (256 / p);
        end else if (dr) begin
            r = v / p;
            if (m == 2'b01 && v >= 128) r = r + 256 - 256 / p;
        end else begin
            r = (v * p) % 256;
        end
        return r[7:0];
    endfunction

    // One cycle of streaming traffic with scoreboard and stall-hold checks.
    task automatic step(input logic iv, input logic [7:0] d, input logic [2:0] s,
                        input logic dr, input logic [1:0] m, input logic ordy,
                        output logic accepted);
        logic [7:0] e;
        @(negedge clk);
        in_valid = iv; data_in = d; shift = s; dir = dr; mode = m; out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(data_out), 32'(prev_data));
            chk("hold_zero", 32'(out_zero), 32'(prev_zero));
        end
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_data", 32'(data_out), 32'(e));
                chk("result_zero", 32'(out_zero), 32'(e == 8'h00));
                popped++;
            end
        end
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(ref_model(d, int'(s), dr, m));
        prev_stall = out_valid && !out_ready;
        prev_data  = data_out;
        prev_zero  = out_zero;
    endtask

    // Single isolated beat with exact latency checking.
    task automatic send_one(input vec_t v, input int idx);
        @(negedge clk);
        in_valid = 1'b1; data_in = v.d; shift = v.s; dir = v.dr; mode = v.m; out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat_c1", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_lat_c2", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_lat_c3", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_data", idx), 32'(data_out), 32'(v.exp));
        chk($sformatf("vec%0d_zero", idx), 32'(out_zero), 32'(v.ez));
    endtask

    initial begin
        logic acc;
        logic stall;
        int   sent;
        int   accepted_n;

        vecs[0]  = '{8'h96, 3'd3, 1'b0, 2'b00, 8'hB0, 1'b0};
        vecs[1]  = '{8'h96, 3'd2, 1'b1, 2'b01, 8'hE5, 1'b0};
        vecs[2]  = '{8'h96, 3'd2, 1'b1, 2'b00, 8'h25, 1'b0};
        vecs[3]  = '{8'h80, 3'd7, 1'b1, 2'b00, 8'h01, 1'b0};
        vecs[4]  = '{8'h96, 3'd3, 1'b0, 2'b10, 8'hB4, 1'b0};
        vecs[5]  = '{8'h96, 3'd3, 1'b1, 2'b10, 8'hD2, 1'b0};
        vecs[6]  = '{8'h01, 3'd1, 1'b1, 2'b00, 8'h00, 1'b1};
        vecs[7]  = '{8'h5A, 3'd0, 1'b1, 2'b10, 8'h5A, 1'b0};
        vecs[8]  = '{8'hF0, 3'd4, 1'b1, 2'b11, 8'h0F, 1'b0};
        vecs[9]  = '{8'h81, 3'd1, 1'b0, 2'b01, 8'h02, 1'b0};
        vecs[10] = '{8'h81, 3'd0, 1'b1, 2'b01, 8'h81, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; data_in = 8'h00; shift = 3'd0;
        dir = 1'b0; mode = 2'b00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_out_zero", 32'(out_zero), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) send_one(vecs[i], i);

        // Eight back-to-back beats with a five-cycle downstream stall.
        prev_stall = 1'b0; popped = 0; sent = 0;
        for (int c = 0; c < 40; c++) begin
            stall = (c >= 4 && c < 9);
            step(sent < 8, 8'(8'h13 * sent + 1), 3'(sent), sent[0], 2'(sent % 3), !stall, acc);
            if (stall && out_valid) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (acc) sent++;
        end
        chk("stall_sent", 32'(sent), 32'd8);
        chk("stall_popped", 32'(popped), 32'd8);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 3'(i + 1), 1'b0, 2'b00, 1'b1, acc);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        chk("midrst_out_zero", 32'(out_zero), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_result", 32'(out_valid), 32'd0);
        end
        send_one(vecs[0], 100);

        // Randomised traffic against the reference model.
        popped = 0; accepted_n = 0;
        for (int c = 0; c < 60000 && accepted_n < 10000; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, acc);
            if (acc) accepted_n++;
        end
        chk("random_accepted", 32'(accepted_n), 32'd10000);
        for (int c = 0; c < 10; c++) step(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, acc);
        chk("random_popped", 32'(popped), 32'(accepted_n));
        chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
